// File: rtl/int_vector_mac_sequencer.sv
// Control stage for the integer vector MAC: accepts a job length, clears the
// MAC, streams operand chunks, then saturates and returns the final sum.
module int_vector_mac_sequencer #(
    parameter  int DataWidth        = 8,
    parameter  int Size             = 64,
    parameter  int AccumulatorWidth = 32,
    parameter  int OutWidth         = 16,
    parameter  int MaxChunks        = 256,
    localparam int LenWidth         = $clog2(MaxChunks + 1),
    localparam int VecWidth         = Size * DataWidth
) (
    input  logic                        clock,
    input  logic                        reset_ni,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic [LenWidth-1:0]         cmd_len_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [VecWidth-1:0]         op0_vec_i,
    input  logic [VecWidth-1:0]         op1_vec_i,
    output logic                        mac_clear_o,
    output logic [VecWidth-1:0]         op0_vec_o,
    output logic [VecWidth-1:0]         op1_vec_o,
    input  logic [AccumulatorWidth-1:0] mac_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [OutWidth-1:0]         res_data_o,
    output logic                        res_sat_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_CAPTURE,
        ST_OUT
    } state_t;

    localparam logic [LenWidth-1:0] MaxLen = LenWidth'(MaxChunks);
    localparam logic signed [AccumulatorWidth-1:0] SatMaxAcc =
        {{(AccumulatorWidth - OutWidth + 1){1'b0}}, {(OutWidth - 1){1'b1}}};
    localparam logic signed [AccumulatorWidth-1:0] SatMinAcc = ~SatMaxAcc;
    localparam logic [OutWidth-1:0] SatMaxOut = {1'b0, {(OutWidth - 1){1'b1}}};
    localparam logic [OutWidth-1:0] SatMinOut = {1'b1, {(OutWidth - 1){1'b0}}};

    state_t                r_state;
    logic [LenWidth-1:0]   r_len;
    logic                  r_cmd_ready;
    logic                  r_in_ready;
    logic                  r_mac_clear;
    logic [VecWidth-1:0]   r_op0;
    logic [VecWidth-1:0]   r_op1;
    logic                  r_res_valid;
    logic [OutWidth-1:0]   r_res_data;
    logic                  r_res_sat;

    logic [LenWidth-1:0]   w_len_clamped;
    logic signed [AccumulatorWidth-1:0] w_acc;
    logic                  w_sat_hi;
    logic                  w_sat_lo;
    logic [OutWidth-1:0]   w_sat_data;

    // Clamp the requested length and saturate the incoming accumulator.
    always_comb begin
        w_len_clamped = (cmd_len_i > MaxLen) ? MaxLen : cmd_len_i;
        w_acc         = mac_i;
        w_sat_hi      = (w_acc > SatMaxAcc);
        w_sat_lo      = (w_acc < SatMinAcc);
        w_sat_data    = w_acc[OutWidth-1:0];
        if (w_sat_hi) begin
            w_sat_data = SatMaxOut;
        end else if (w_sat_lo) begin
            w_sat_data = SatMinOut;
        end
    end

    // Job FSM; every output is registered and set for the state being entered.
    // cmd_ready comes up one cycle after reset release, so the IDLE handshake
    // is qualified by the registered ready rather than by the state alone.
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_cmd_ready <= 1'b0;
            r_in_ready  <= 1'b0;
            r_mac_clear <= 1'b0;
            r_op0       <= '0;
            r_op1       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sat   <= 1'b0;
        end else begin
            r_op0 <= '0;
            r_op1 <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i && r_cmd_ready) begin
                        r_len       <= w_len_clamped;
                        r_cmd_ready <= 1'b0;
                        r_mac_clear <= 1'b1;
                        r_state     <= ST_CLEAR;
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    r_mac_clear <= 1'b0;
                    if (r_len == '0) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_valid_i && r_in_ready) begin
                        r_op0 <= op0_vec_i;
                        r_op1 <= op1_vec_i;
                        r_len <= r_len - LenWidth'(1);
                        if (r_len == LenWidth'(1)) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_res_data  <= w_sat_data;
                    r_res_sat   <= w_sat_hi | w_sat_lo;
                    r_res_valid <= 1'b1;
                    r_state     <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready_i) begin
                        r_res_valid <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o = r_cmd_ready;
    assign in_ready_o  = r_in_ready;
    assign mac_clear_o = r_mac_clear;
    assign op0_vec_o   = r_op0;
    assign op1_vec_o   = r_op1;
    assign res_valid_o = r_res_valid;
    assign res_data_o  = r_res_data;
    assign res_sat_o   = r_res_sat;

endmodule

// File: doc/int_vector_mac_sequencer.md
# int_vector_mac_sequencer

Upstream control stage for the integer vector MAC family (twos/sign-magnitude, single/dual adder). It accepts a job command giving a dot-product length in `Size`-element chunks, streams operand-vector pairs into the MAC one chunk per cycle over a valid/ready handshake, and clears the MAC accumulator before each job. It then captures the final accumulator, saturates it to `OutWidth`, and presents it on a valid/ready result port.

## Interface
- `DataWidth`, default 8: operand element width (signed).
- `Size`, default 64: elements per chunk; matches the MAC `Size`.
- `AccumulatorWidth`, default 32: MAC accumulator width.
- `OutWidth`, default 16: result width; must satisfy `OutWidth <= AccumulatorWidth`.
- `MaxChunks`, default 256: largest chunk count per job.
- `LenWidth` (localparam): `$clog2(MaxChunks+1)`.

Ports:
- `clock`  in  1  single clock.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  job command valid.
- `cmd_ready_o`  out  1  high only in IDLE.
- `cmd_len_i`  in  LenWidth  chunk count; values above `MaxChunks` are clamped to `MaxChunks`.
- `in_valid_i`  in  1  operand chunk valid.
- `in_ready_o`  out  1  high only in RUN.
- `op0_vec_i`, `op1_vec_i`  in  Size*DataWidth  signed operand chunk.
- `mac_clear_o`  out  1  synchronous clear for the MAC accumulator register.
- `op0_vec_o`, `op1_vec_o`  out  Size*DataWidth  registered operands driven to the MAC.
- `mac_i`  in  AccumulatorWidth  MAC `mac_o`.
- `res_valid_o`  out  1  result valid.
- `res_ready_i`  in  1  result ready.
- `res_data_o`  out  OutWidth  saturated result (signed).
- `res_sat_o`  out  1  high when saturation occurred; qualified by `res_valid_o`.

## Operation
- The FSM has six states: IDLE, CLEAR, RUN, DRAIN, CAPTURE, OUT.
- IDLE:
  - `cmd_valid_i & cmd_ready_o` loads the remaining-chunk counter with the clamped `cmd_len_i`.
  - FSM moves to CLEAR.
- CLEAR (1 cycle):
  - `mac_clear_o` is 1.
  - Next state is RUN, or DRAIN if the length is 0.
- RUN:
  - An input handshake registers `op0_vec_i`/`op1_vec_i` onto `op*_vec_o` for the next cycle and decrements the counter.
  - A cycle with no handshake registers zeros, so the MAC accumulates 0.
  - The handshake that brings the counter to 0 moves the FSM to DRAIN.
- DRAIN (1 cycle): the MAC absorbs the last chunk.
- CAPTURE (1 cycle):
  - `op*_vec_o` are zero.
  - At the end of the cycle, `res_data_o` is loaded with `sat(mac_i)` and `res_sat_o` with the overflow flag.
- `sat(x)`:
  - `x > 2^(OutWidth-1)-1` gives max with sat=1.
  - `x < -2^(OutWidth-1)` gives min with sat=1.
  - Otherwise the result is `x` truncated, sat=0.
- OUT:
  - `res_valid_o` is 1; `res_data_o` and `res_sat_o` are held stable.
  - `op*_vec_o` stay zero.
  - The handshake on `res_valid_o & res_ready_i` moves the FSM to IDLE.
- `op*_vec_o` are zero in every state except the cycle after a RUN handshake.
- A length of 0 yields result 0 (the MAC is cleared and no data is accumulated).
- Reset mid-job aborts the job: all state returns to IDLE and no result is emitted. The next job is correct because of the CLEAR state.

## Timing
- Reset values: all outputs are 0 and the state is IDLE (`cmd_ready_o` becomes 1 on the first cycle after reset release).
- Cycle plan for a command accepted in cycle 0 with N chunks sent back-to-back:
  - CLEAR in cycle 1.
  - Input handshakes in cycles 2..N+1.
  - DRAIN in cycle N+2.
  - CAPTURE in cycle N+3.
  - `res_valid_o` from cycle N+4.
- Minimum command-to-result latency is N+4 cycles. Each bubble cycle in RUN adds 1 cycle.
- Operands presented in cycle t are in `mac_i` at cycle t+1.
- Command and input are never accepted in the same cycle. Only one job is in flight.
- `in_valid_i` is ignored outside RUN. `cmd_valid_i` is ignored outside IDLE.

## Test plan
- Single chunk: N=1, op0=all 1, op1=all 2 (Size 64) -> `res_data_o`=128, sat=0, `res_valid_o` rises exactly 5 cycles after the command handshake.
- Multi-chunk back-to-back: N=4, op0=all -3, op1=all 5 -> -3840, sat=0, valid at cycle 8.
- Bubbles: N=3, chunks all 1 × all 1, with 2 idle cycles before each chunk -> 192, valid at cycle 13, no extra accumulation.
- Saturation: N=8, all 127×127 (sum 8,258,048) -> 32767, sat=1; all -128×127 -> -32768, sat=1.
- Backpressure and zero length: hold `res_ready_i`=0 for 10 cycles -> data stable, `cmd_ready_o`=0. After the handshake, issue a len=0 command -> result 0 at cycle 4.
- Reset mid-RUN: assert `reset_ni`=0 after 2 of 4 chunks -> all outputs 0 immediately. The next job (N=1, 1×1) -> 64, with no stale sum.
